// File: rtl/pool_layer_engine_if.sv
// Bus between the pooling engine, load_block (image fetch) and the DMA (result write-back).
// The engine takes the master modport; the surrounding fabric or a testbench takes the slave modport.
interface pool_layer_engine_if #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int BUF_DEPTH = 1024
);
    logic                     enable;
    logic [ADDR_W-1:0]        imgsNumber;
    logic [ADDR_W-1:0]        imgSize;
    logic [ADDR_W-1:0]        imgsAddress;
    logic [ADDR_W-1:0]        windowSize;
    logic                     loadDone;
    logic signed [DATA_W-1:0] loadOut [BUF_DEPTH];
    logic                     loadEnable;
    logic [ADDR_W-1:0]        loadAddr;
    logic [ADDR_W-1:0]        loadSize;
    logic [ADDR_W-1:0]        writeAddr;
    logic signed [DATA_W-1:0] writeOut;
    logic                     writeEnable;
    logic                     done;

    modport master (
        input  enable, imgsNumber, imgSize, imgsAddress, windowSize, loadDone, loadOut,
        output loadEnable, loadAddr, loadSize, writeAddr, writeOut, writeEnable, done
    );

    modport slave (
        output enable, imgsNumber, imgSize, imgsAddress, windowSize, loadDone, loadOut,
        input  loadEnable, loadAddr, loadSize, writeAddr, writeOut, writeEnable, done
    );
endinterface

// File: rtl/pool_layer_engine.sv
// Non-overlapping 2-D pooling engine: average pooling by default, signed max pooling
// when the MAX_POOL_EN macro is defined.
module pool_layer_engine #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int BUF_DEPTH = 1024
) (
    input logic               clk,
    input logic               reset,
    pool_layer_engine_if.master bus
);
    localparam int ACC_W = 22;
    localparam int IDX_W = $clog2(BUF_DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD_REQ  = 3'd1;
    localparam logic [2:0] S_LOAD_WAIT = 3'd2;
    localparam logic [2:0] S_ACCUM     = 3'd3;
    localparam logic [2:0] S_WRITE     = 3'd4;
    localparam logic [2:0] S_NEXT      = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic [2:0]              state_r;
    logic [ADDR_W-1:0]       num_r, n_r, w_r, m_r;
    logic [1:0]              log2w_r;
    logic [ADDR_W-1:0]       img_r, ox_r, oy_r, wx_r, wy_r;
    logic [ADDR_W-1:0]       out_addr_r;
    logic signed [ACC_W-1:0] acc_r;

    logic [1:0]              w_log2_s;
    logic                    w_ok_s;
    logic                    cfg_bad_s;
    logic [ADDR_W-1:0]       nn_in_s;
    logic [ADDR_W-1:0]       row_s, col_s, idx_s;
    logic signed [DATA_W-1:0] elem_s;
    logic signed [ACC_W-1:0] elem_ext_s, acc_next_s, res_wide_s;
    logic                    first_s, last_s;
    logic [2:0]              shamt_s;

    // Decode the requested window side and reject configurations that cannot run.
    always_comb begin
        w_log2_s = 2'd0;
        w_ok_s   = 1'b1;
        case (bus.windowSize)
            ADDR_W'(1): w_log2_s = 2'd0;
            ADDR_W'(2): w_log2_s = 2'd1;
            ADDR_W'(4): w_log2_s = 2'd2;
            ADDR_W'(8): w_log2_s = 2'd3;
            default:    w_ok_s   = 1'b0;
        endcase
        cfg_bad_s = (bus.imgsNumber == ADDR_W'(0)) || !w_ok_s || (bus.windowSize > bus.imgSize);
        nn_in_s   = ADDR_W'(bus.imgSize * bus.imgSize);
    end

    // Address the current window element in the buffer and fold it into the accumulator.
    always_comb begin
        row_s      = ADDR_W'(oy_r * w_r) + wy_r;
        col_s      = ADDR_W'(ox_r * w_r) + wx_r;
        idx_s      = ADDR_W'(row_s * n_r) + col_s;
        elem_s     = bus.loadOut[IDX_W'(idx_s)];
        elem_ext_s = {{(ACC_W-DATA_W){elem_s[DATA_W-1]}}, elem_s};
        first_s    = (wx_r == ADDR_W'(0)) && (wy_r == ADDR_W'(0));
        last_s     = (wx_r == w_r - ADDR_W'(1)) && (wy_r == w_r - ADDR_W'(1));
        shamt_s    = {log2w_r, 1'b0};
`ifdef MAX_POOL_EN
        if (first_s || (elem_ext_s > acc_r)) begin
            acc_next_s = elem_ext_s;
        end else begin
            acc_next_s = acc_r;
        end
        res_wide_s = acc_next_s;
`else
        if (first_s) begin
            acc_next_s = elem_ext_s;
        end else begin
            acc_next_s = acc_r + elem_ext_s;
        end
        // Arithmetic shift floors toward -inf, matching the average definition.
        res_wide_s = acc_next_s >>> shamt_s;
`endif
    end

    // Run control: sequencing of loads, window accumulation and result writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= S_IDLE;
            num_r           <= ADDR_W'(0);
            n_r             <= ADDR_W'(0);
            w_r             <= ADDR_W'(0);
            m_r             <= ADDR_W'(0);
            log2w_r         <= 2'd0;
            img_r           <= ADDR_W'(0);
            ox_r            <= ADDR_W'(0);
            oy_r            <= ADDR_W'(0);
            wx_r            <= ADDR_W'(0);
            wy_r            <= ADDR_W'(0);
            out_addr_r      <= ADDR_W'(0);
            acc_r           <= ACC_W'(0);
            bus.loadEnable  <= 1'b0;
            bus.loadAddr    <= ADDR_W'(0);
            bus.loadSize    <= ADDR_W'(0);
            bus.writeAddr   <= ADDR_W'(0);
            bus.writeOut    <= DATA_W'(0);
            bus.writeEnable <= 1'b0;
            bus.done        <= 1'b0;
        end else if ((state_r != S_IDLE) && !bus.enable) begin
            state_r         <= S_IDLE;
            bus.loadEnable  <= 1'b0;
            bus.loadAddr    <= ADDR_W'(0);
            bus.loadSize    <= ADDR_W'(0);
            bus.writeAddr   <= ADDR_W'(0);
            bus.writeOut    <= DATA_W'(0);
            bus.writeEnable <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.enable && cfg_bad_s) begin
                        state_r  <= S_DONE;
                        bus.done <= 1'b1;
                    end else if (bus.enable) begin
                        state_r        <= S_LOAD_REQ;
                        num_r          <= bus.imgsNumber;
                        n_r            <= bus.imgSize;
                        w_r            <= bus.windowSize;
                        log2w_r        <= w_log2_s;
                        m_r            <= bus.imgSize >> w_log2_s;
                        img_r          <= ADDR_W'(0);
                        ox_r           <= ADDR_W'(0);
                        oy_r           <= ADDR_W'(0);
                        wx_r           <= ADDR_W'(0);
                        wy_r           <= ADDR_W'(0);
                        // Results are packed directly after the last input image.
                        out_addr_r     <= bus.imgsAddress + ADDR_W'(bus.imgsNumber * nn_in_s);
                        bus.loadEnable <= 1'b1;
                        bus.loadAddr   <= bus.imgsAddress;
                        bus.loadSize   <= nn_in_s;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_LOAD_REQ: state_r <= S_LOAD_WAIT;
                S_LOAD_WAIT: begin
                    if (bus.loadDone) begin
                        state_r        <= S_ACCUM;
                        bus.loadEnable <= 1'b0;
                    end else begin
                        state_r <= S_LOAD_WAIT;
                    end
                end
                S_ACCUM: begin
                    acc_r <= acc_next_s;
                    if (last_s) begin
                        state_r         <= S_WRITE;
                        wx_r            <= ADDR_W'(0);
                        wy_r            <= ADDR_W'(0);
                        bus.writeEnable <= 1'b1;
                        bus.writeAddr   <= out_addr_r;
                        bus.writeOut    <= DATA_W'(res_wide_s);
                        out_addr_r      <= out_addr_r + ADDR_W'(1);
                    end else if (wx_r == w_r - ADDR_W'(1)) begin
                        wx_r <= ADDR_W'(0);
                        wy_r <= wy_r + ADDR_W'(1);
                    end else begin
                        wx_r <= wx_r + ADDR_W'(1);
                    end
                end
                S_WRITE: begin
                    state_r         <= S_NEXT;
                    bus.writeEnable <= 1'b0;
                end
                S_NEXT: begin
                    if (ox_r != m_r - ADDR_W'(1)) begin
                        ox_r    <= ox_r + ADDR_W'(1);
                        state_r <= S_ACCUM;
                    end else if (oy_r != m_r - ADDR_W'(1)) begin
                        ox_r    <= ADDR_W'(0);
                        oy_r    <= oy_r + ADDR_W'(1);
                        state_r <= S_ACCUM;
                    end else if (img_r == num_r - ADDR_W'(1)) begin
                        state_r  <= S_DONE;
                        bus.done <= 1'b1;
                    end else begin
                        ox_r           <= ADDR_W'(0);
                        oy_r           <= ADDR_W'(0);
                        img_r          <= img_r + ADDR_W'(1);
                        state_r        <= S_LOAD_REQ;
                        bus.loadEnable <= 1'b1;
                        bus.loadAddr   <= bus.loadAddr + bus.loadSize;
                    end
                end
                S_DONE:  state_r <= S_DONE;
                default: state_r <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pool_layer_engine.sv
// Directed self-checking bench for pool_layer_engine; expectations follow the build's
// MAX_POOL_EN setting (average pooling when undefined).
module tb_pool_layer_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic signed [15:0] mem [512];
    logic [15:0]        wr_addr [64];
    logic signed [15:0] wr_data [64];
    logic [15:0]        ld_addr [8];
    logic [15:0]        ld_size [8];
    int                 wr_n, ld_n;

    pool_layer_engine_if #(.DATA_W(16), .ADDR_W(16), .BUF_DEPTH(1024)) bus();

    pool_layer_engine #(.DATA_W(16), .ADDR_W(16), .BUF_DEPTH(1024)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic set_cfg(input int num, input int n, input int base, input int w);
        bus.imgsNumber  = 16'(num);
        bus.imgSize     = 16'(n);
        bus.imgsAddress = 16'(base);
        bus.windowSize  = 16'(w);
    endtask

    // Acts as load_block and the DMA until done or the cycle budget runs out.
    task automatic run_job(input int max_cycles, output int cycles);
        wr_n = 0;
        ld_n = 0;
        cycles = 0;
        bus.enable = 1'b1;
        while (cycles < max_cycles && bus.done !== 1'b1) begin
            @(negedge clk);
            cycles++;
            if (bus.loadEnable === 1'b1 && bus.loadDone === 1'b0) begin
                ld_addr[ld_n] = bus.loadAddr;
                ld_size[ld_n] = bus.loadSize;
                if (ld_n < 7) ld_n++;
                for (int i = 0; i < int'(bus.loadSize) && i < 1024; i++)
                    bus.loadOut[i] = mem[(int'(bus.loadAddr) + i) % 512];
            end
            bus.loadDone = bus.loadEnable;
            if (bus.writeEnable === 1'b1) begin
                wr_addr[wr_n] = bus.writeAddr;
                wr_data[wr_n] = bus.writeOut;
                if (wr_n < 63) wr_n++;
            end
        end
    endtask

    task automatic stop_job();
        bus.enable   = 1'b0;
        bus.loadDone = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.loadEnable, bus.writeEnable, bus.done, bus.loadAddr, bus.loadSize,
             bus.writeAddr, bus.writeOut} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got le=%b we=%b done=%b la=%0d ls=%0d wa=%0d wo=%0d, want all 0",
                     bus.loadEnable, bus.writeEnable, bus.done, bus.loadAddr, bus.loadSize,
                     bus.writeAddr, bus.writeOut);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.loadEnable !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL idle_quiet: got le=%b done=%b, want 0 0", bus.loadEnable, bus.done);
        end
    endtask

    task automatic test_multi_image();
        int cyc;
        logic signed [15:0] exp_d [12];
`ifdef MAX_POOL_EN
        exp_d = '{16'sd5, 16'sd7, 16'sd13, 16'sd15, 16'sd21, 16'sd23, 16'sd29, 16'sd31,
                  16'sd37, 16'sd39, 16'sd45, 16'sd47};
`else
        exp_d = '{16'sd2, 16'sd4, 16'sd10, 16'sd12, 16'sd18, 16'sd20, 16'sd26, 16'sd28,
                  16'sd34, 16'sd36, 16'sd42, 16'sd44};
`endif
        for (int i = 0; i < 48; i++) mem[i] = 16'(i);
        set_cfg(3, 4, 0, 2);
        run_job(600, cyc);
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_err++;
            $display("FAIL multi_done: got done=%b after %0d cycles, want 1", bus.done, cyc);
        end
        n_cmp++;
        if (wr_n != 12) begin
            n_err++;
            $display("FAIL multi_wr_count: got %0d writes, want 12", wr_n);
        end
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (wr_addr[i] !== 16'(48 + i) || wr_data[i] !== exp_d[i]) begin
                n_err++;
                $display("FAIL multi_write%0d: got (%0d,%0d), want (%0d,%0d)",
                         i, wr_addr[i], wr_data[i], 48 + i, exp_d[i]);
            end
        end
        n_cmp++;
        if (ld_n != 3 || ld_addr[0] !== 16'd0 || ld_addr[1] !== 16'd16 || ld_addr[2] !== 16'd32
            || ld_size[0] !== 16'd16 || ld_size[2] !== 16'd16) begin
            n_err++;
            $display("FAIL multi_loads: got n=%0d addr=%0d,%0d,%0d size=%0d, want 3 loads 0,16,32 size 16",
                     ld_n, ld_addr[0], ld_addr[1], ld_addr[2], ld_size[0]);
        end
        stop_job();
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL multi_done_clear: got done=%b after enable=0, want 0", bus.done);
        end
    endtask

    task automatic test_negative_window();
        int cyc;
        logic signed [15:0] exp_v;
`ifdef MAX_POOL_EN
        exp_v = -16'sd1;
`else
        exp_v = -16'sd3;
`endif
        mem[100] = -16'sd1;
        mem[101] = -16'sd2;
        mem[102] = -16'sd3;
        mem[103] = -16'sd4;
        set_cfg(1, 2, 100, 2);
        run_job(100, cyc);
        n_cmp++;
        if (wr_n != 1 || wr_addr[0] !== 16'd104 || wr_data[0] !== exp_v) begin
            n_err++;
            $display("FAIL negative_window: got n=%0d (%0d,%0d), want 1 (104,%0d)",
                     wr_n, wr_addr[0], wr_data[0], exp_v);
        end
        stop_job();
    endtask

    task automatic test_bad_config();
        int cyc;
        int nums [4] = '{0, 1, 1, 1};
        int sizes [4] = '{4, 4, 4, 1};
        int wins [4] = '{2, 3, 0, 2};
        for (int k = 0; k < 4; k++) begin
            set_cfg(nums[k], sizes[k], 0, wins[k]);
            run_job(10, cyc);
            n_cmp++;
            if (bus.done !== 1'b1 || cyc > 2 || wr_n != 0 || ld_n != 0) begin
                n_err++;
                $display("FAIL bad_config%0d: got done=%b cycles=%0d writes=%0d loads=%0d, want 1 <=2 0 0",
                         k, bus.done, cyc, wr_n, ld_n);
            end
            stop_job();
        end
    endtask

    task automatic test_trailing_ignored();
        int cyc;
        logic signed [15:0] exp_d [4];
`ifdef MAX_POOL_EN
        exp_d = '{16'sd5, 16'sd7, 16'sd13, 16'sd15};
`else
        exp_d = '{16'sd2, 16'sd4, 16'sd10, 16'sd12};
`endif
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    mem[200 + 25 * k + 5 * r + c] = (r < 4 && c < 4) ? 16'(4 * r + c) : 16'sd1000;
        set_cfg(2, 5, 200, 2);
        run_job(400, cyc);
        n_cmp++;
        if (wr_n != 8 || ld_n != 2 || ld_size[0] !== 16'd25 || ld_addr[1] !== 16'd225) begin
            n_err++;
            $display("FAIL trailing_counts: got writes=%0d loads=%0d size=%0d addr1=%0d, want 8 2 25 225",
                     wr_n, ld_n, ld_size[0], ld_addr[1]);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (wr_addr[i] !== 16'(250 + i) || wr_data[i] !== exp_d[i % 4]) begin
                n_err++;
                $display("FAIL trailing_write%0d: got (%0d,%0d), want (%0d,%0d)",
                         i, wr_addr[i], wr_data[i], 250 + i, exp_d[i % 4]);
            end
        end
        stop_job();
    endtask

    task automatic test_abort_restart();
        bit found;
        for (int i = 32; i < 64; i++) mem[i] = 16'(i);
        set_cfg(2, 4, 32, 2);
        bus.enable = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (bus.loadEnable === 1'b1 && bus.loadAddr === 16'd48 && bus.loadDone === 1'b0) begin
                found = 1'b1;
            end else begin
                if (bus.loadEnable === 1'b1)
                    for (int i = 0; i < 16; i++) bus.loadOut[i] = mem[int'(bus.loadAddr) + i];
                bus.loadDone = bus.loadEnable;
            end
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL abort_second_load: got no request at 48 within budget, want one");
        end
        bus.loadDone = 1'b0;
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.loadEnable, bus.writeEnable, bus.done, bus.loadAddr, bus.loadSize} !== '0) begin
            n_err++;
            $display("FAIL abort_outputs: got le=%b we=%b done=%b la=%0d ls=%0d, want all 0",
                     bus.loadEnable, bus.writeEnable, bus.done, bus.loadAddr, bus.loadSize);
        end
        bus.enable = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.loadEnable !== 1'b1 || bus.loadAddr !== 16'd32 || bus.loadSize !== 16'd16) begin
            n_err++;
            $display("FAIL abort_restart: got le=%b la=%0d ls=%0d, want 1 32 16",
                     bus.loadEnable, bus.loadAddr, bus.loadSize);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.loadEnable, bus.writeEnable, bus.done, bus.loadAddr, bus.loadSize,
             bus.writeAddr, bus.writeOut} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: got le=%b la=%0d ls=%0d wa=%0d, want all 0",
                     bus.loadEnable, bus.loadAddr, bus.loadSize, bus.writeAddr);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.loadEnable !== 1'b1 || bus.loadAddr !== 16'd32) begin
            n_err++;
            $display("FAIL midreset_restart: got le=%b la=%0d, want 1 32", bus.loadEnable, bus.loadAddr);
        end
        stop_job();
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.loadDone = 1'b0;
        set_cfg(0, 0, 0, 0);
        for (int i = 0; i < 1024; i++) bus.loadOut[i] = 16'sd0;
        for (int i = 0; i < 512; i++) mem[i] = 16'sd0;
        test_reset();
        test_multi_image();
        test_negative_window();
        test_bad_config();
        test_trailing_ignored();
        test_abort_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
